irq_flag_ctrl: RTL and testbench
================================

IRQ_FLAG_CTRL -- requirements
Module: irq_flag_ctrl

Interface
REQ-001 The block SHALL have these ports; clock and reset are listed first.
- CLK  in  1  single clock; all state updates on its rising edge.
- SYNC_RES  in  1  reset; synchronous, active-high.
- A  in  16  CPU address bus.
- DIN  in  8  CPU write data.
- RD  in  1  CPU read strobe, level.
- WR  in  1  CPU write strobe, level.
- PERIPH_REQ  in  8  peripheral request levels; bit0 VBlank, bit1 STAT, bit2 Timer, bit3 Serial, bit4 Joypad, bits 7:5 extension.
- CPU_IRQ_ACK  in  8  per-bit acknowledge from the CPU interrupt priority encoder; active-high.
- CPU_IRQ_TRIG  out  8  pending interrupt flags (IF) to the CPU IRQ logic.
- DOUT  out  8  read data.
- DOUT_EN  out  1  DOUT valid; drives the shared data bus.
- IF_SEL  out  1  combinational; 1 when A == 0xFF0F.

Function
REQ-002 The block SHALL hold an 8-bit flag register (flags) and an 8-bit previous-level register (prev).
REQ-003 The block SHALL compute edge[i] = PERIPH_REQ[i] & ~prev[i] and load prev with PERIPH_REQ every cycle.
REQ-004 The block SHALL define wr_hit as WR & IF_SEL.
REQ-005 The block SHALL update flags every cycle as flags_next = ((wr_hit ? DIN : flags) & ~CPU_IRQ_ACK) | edge.
- Precedence: an edge wins over an ack or write in the same cycle, so no request is lost.
- Ack wins over write data.
REQ-006 The block SHALL drive CPU_IRQ_TRIG directly from flags, with no combinational path from any input.
REQ-007 An edge at cycle N SHALL appear on CPU_IRQ_TRIG at cycle N+1 (one-cycle latency).
REQ-008 A held PERIPH_REQ level SHALL set a flag only once, and SHALL set it again only after a low-then-high transition.
REQ-009 An ack held for several cycles SHALL keep the bit clear, and SHALL NOT block a fresh edge.
REQ-010 The block SHALL use a two-state read machine, IDLE and DATA.
- IDLE -> DATA when RD & IF_SEL; the read value is captured into DOUT at that edge.
- DATA -> DATA while RD & IF_SEL persists; DOUT is re-captured each cycle.
- DATA -> IDLE otherwise.
- DOUT_EN is 1 only in DATA.
REQ-011 The read value SHALL be flags_next, so a same-cycle set or clear is visible in the read.
REQ-012 RD and WR asserted together on 0xFF0F SHALL perform the write, and the read SHALL return the post-write value.
REQ-013 Accesses to any address other than 0xFF0F SHALL leave flags unchanged and keep DOUT_EN at 0.

Reset
REQ-014 While SYNC_RES = 1 at a clock edge, the block SHALL apply these values:
- flags = 0x00 (CPU_IRQ_TRIG = 0x00).
- DOUT = 0x00, DOUT_EN = 0, read state = IDLE.
- prev = PERIPH_REQ, so levels already high at reset release cause no edge.
REQ-015 Reset SHALL override edges, acks and writes in the same cycle.
REQ-016 A reset during a read SHALL abort it, and DOUT_EN SHALL be 0 in the next cycle.

Configuration
REQ-017 With macro IRQ_FLAG_EXT_BITS_EN defined, bits 7:5 SHALL behave exactly like bits 4:0.
REQ-018 Without IRQ_FLAG_EXT_BITS_EN, the block SHALL behave as follows for bits 7:5:
- flags[7:5] are forced to 0 and no prev storage exists for them.
- CPU_IRQ_TRIG[7:5] = 0.
- DIN[7:5] writes are ignored.
- Reads return 1 in bits 7:5 (DMG-compatible, e.g. empty IF reads 0xE0).

Verification
REQ-019 Bench scenario: reset, then PERIPH_REQ 0x00 -> 0x04 -> CPU_IRQ_TRIG = 0x04 one cycle later; holding 0x04 for 10 cycles keeps 0x04 and causes no further set.
REQ-020 Bench scenario: flags 0x05, CPU_IRQ_ACK = 0x01 for 3 cycles -> CPU_IRQ_TRIG = 0x04 after the first cycle and stays 0x04.
REQ-021 Bench scenario: flags 0x01, same cycle CPU_IRQ_ACK = 0x01 and PERIPH_REQ[0] rising -> CPU_IRQ_TRIG = 0x01 next cycle.
REQ-022 Bench scenario: WR at 0xFF0F with DIN = 0x13 and CPU_IRQ_ACK = 0x02 in the same cycle -> flags = 0x11.
- Without the macro, DIN = 0xFF then RD -> DOUT = 0xFF, CPU_IRQ_TRIG = 0x1F.
REQ-023 Bench scenario: RD at 0xFF0F with flags 0x08 -> DOUT_EN = 1 and DOUT = 0xE8 next cycle (no macro).
- RD at 0xFF0E -> DOUT_EN stays 0.
REQ-024 Bench scenario: PERIPH_REQ = 0x1F held high through reset release -> CPU_IRQ_TRIG stays 0x00.
- SYNC_RES asserted mid-read -> DOUT_EN = 0 next cycle.

Source files
------------

// File: rtl/irq_flag_ctrl.sv
// irq_flag_ctrl: interrupt flag (IF) register with edge-detected peripheral
// requests, per-bit CPU acknowledge and a CPU read/write port at 0xFF0F.
//
// Optional feature macro: IRQ_FLAG_EXT_BITS_EN
//   defined   -> bits 7:5 are full flag bits like bits 4:0
//   undefined -> bits 7:5 have no storage, read back as 1, write-ignored
//
// Ports:
//   CLK          in   1   clock, rising edge
//   SYNC_RES     in   1   synchronous active-high reset
//   A            in  16   CPU address bus
//   DIN          in   8   CPU write data
//   RD           in   1   CPU read strobe (level)
//   WR           in   1   CPU write strobe (level)
//   PERIPH_REQ   in   8   peripheral request levels
//   CPU_IRQ_ACK  in   8   per-bit acknowledge, active-high
//   CPU_IRQ_TRIG out  8   pending flags, registered
//   DOUT         out  8   registered read data
//   DOUT_EN      out  1   DOUT valid
//   IF_SEL       out  1   combinational address decode of 0xFF0F
module irq_flag_ctrl (
    input  logic        CLK,
    input  logic        SYNC_RES,
    input  logic [15:0] A,
    input  logic [7:0]  DIN,
    input  logic        RD,
    input  logic        WR,
    input  logic [7:0]  PERIPH_REQ,
    input  logic [7:0]  CPU_IRQ_ACK,
    output logic [7:0]  CPU_IRQ_TRIG,
    output logic [7:0]  DOUT,
    output logic        DOUT_EN,
    output logic        IF_SEL
);
`ifdef IRQ_FLAG_EXT_BITS_EN
    localparam int NB = 8;
`else
    localparam int NB = 5;
`endif
    typedef enum logic {IDLE, DATA} state_t;
    state_t          state, state_next;
    logic [NB-1:0]   flags, prev, flags_next, edge_v;
    logic [7:0]      rd_val;
    logic            wr_hit, rd_hit;
    assign IF_SEL = (A == 16'hFF0F);
    assign wr_hit = WR & IF_SEL;
    assign rd_hit = RD & IF_SEL;
    assign edge_v = PERIPH_REQ[NB-1:0] & ~prev;
    // Edge is OR-ed last so a fresh request survives a same-cycle ack or write.
    assign flags_next = ((wr_hit ? DIN[NB-1:0] : flags) & ~CPU_IRQ_ACK[NB-1:0]) | edge_v;
`ifdef IRQ_FLAG_EXT_BITS_EN
    assign CPU_IRQ_TRIG = flags;
    assign rd_val       = flags_next;
`else
    // Unimplemented upper bits read as 1, matching DMG behaviour.
    logic unused_ext;
    assign unused_ext   = ^{PERIPH_REQ[7:5], DIN[7:5], CPU_IRQ_ACK[7:5]};
    assign CPU_IRQ_TRIG = {3'b000, flags};
    assign rd_val       = {3'b111, flags_next};
`endif
    assign DOUT_EN = (state == DATA);
    always_comb begin
        state_next = rd_hit ? DATA : IDLE;
    end
    always_ff @(posedge CLK) begin
        if (SYNC_RES) begin
            flags <= '0;
            prev  <= PERIPH_REQ[NB-1:0];
            state <= IDLE;
            DOUT  <= 8'h00;
        end else begin
            flags <= flags_next;
            prev  <= PERIPH_REQ[NB-1:0];
            state <= state_next;
            if (rd_hit) DOUT <= rd_val;
        end
    end
endmodule

// File: tb/tb_irq_flag_ctrl.sv
// tb_irq_flag_ctrl: table-driven directed bench for irq_flag_ctrl (default build).
module tb_irq_flag_ctrl;
    logic        CLK = 1'b0;
    logic        SYNC_RES = 1'b1;
    logic [15:0] A = 16'h0000;
    logic [7:0]  DIN = 8'h00;
    logic        RD = 1'b0;
    logic        WR = 1'b0;
    logic [7:0]  PERIPH_REQ = 8'h00;
    logic [7:0]  CPU_IRQ_ACK = 8'h00;
    logic [7:0]  CPU_IRQ_TRIG;
    logic [7:0]  DOUT;
    logic        DOUT_EN;
    logic        IF_SEL;

    int n_vec = 0;
    int n_bad = 0;

    irq_flag_ctrl dut (
        .CLK(CLK), .SYNC_RES(SYNC_RES), .A(A), .DIN(DIN), .RD(RD), .WR(WR),
        .PERIPH_REQ(PERIPH_REQ), .CPU_IRQ_ACK(CPU_IRQ_ACK),
        .CPU_IRQ_TRIG(CPU_IRQ_TRIG), .DOUT(DOUT), .DOUT_EN(DOUT_EN), .IF_SEL(IF_SEL)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic [15:0] a;
        logic [7:0]  din;
        logic        rd;
        logic        wr;
        logic [7:0]  req;
        logic [7:0]  ack;
        logic [7:0]  trig;
        logic        en;
        logic [7:0]  dout;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic rst, logic [15:0] a, logic [7:0] din, logic rd, logic wr,
                                logic [7:0] req, logic [7:0] ack,
                                logic [7:0] trig, logic en, logic [7:0] dout);
        vec_t v;
        v.rst = rst; v.a = a; v.din = din; v.rd = rd; v.wr = wr;
        v.req = req; v.ack = ack; v.trig = trig; v.en = en; v.dout = dout;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one vector's inputs at the falling edge, check the decode, clock it,
    // then check registered outputs just after the rising edge.
    task automatic apply(input vec_t v, input int idx);
        @(negedge CLK);
        SYNC_RES = v.rst; A = v.a; DIN = v.din; RD = v.rd; WR = v.wr;
        PERIPH_REQ = v.req; CPU_IRQ_ACK = v.ack;
        #1;
        chk($sformatf("v%0d if_sel", idx), {7'b0, IF_SEL}, {7'b0, v.a == 16'hFF0F});
        @(posedge CLK);
        #1;
        chk($sformatf("v%0d trig", idx), CPU_IRQ_TRIG, v.trig);
        chk($sformatf("v%0d dout_en", idx), {7'b0, DOUT_EN}, {7'b0, v.en});
        if (v.en) chk($sformatf("v%0d dout", idx), DOUT, v.dout);
    endtask

    localparam logic [15:0] IFA = 16'hFF0F;
    localparam logic [15:0] OTH = 16'hFF0E;

    initial begin
        //                rst  a      din    rd wr req    ack    trig   en dout
        tv.push_back(mk(1, 16'h0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00));
        tv.push_back(mk(0, 16'h0, 8'h00, 0, 0, 8'h04, 8'h00, 8'h04, 0, 8'h00));
        tv.push_back(mk(0, 16'h0, 8'h00, 0, 0, 8'h04, 8'h00, 8'h04, 0, 8'h00));
        tv.push_back(mk(0, 16'h0, 8'h00, 0, 0, 8'h05, 8'h00, 8'h05, 0, 8'h00));
        tv.push_back(mk(0, 16'h0, 8'h00, 0, 0, 8'h05, 8'h01, 8'h04, 0, 8'h00));
        tv.push_back(mk(0, 16'h0, 8'h00, 0, 0, 8'h05, 8'h01, 8'h04, 0, 8'h00));
        tv.push_back(mk(0, 16'h0, 8'h00, 0, 0, 8'h05, 8'h01, 8'h04, 0, 8'h00));
        tv.push_back(mk(0, 16'h0, 8'h00, 0, 0, 8'h04, 8'h00, 8'h04, 0, 8'h00));
        tv.push_back(mk(0, IFA,   8'h01, 0, 1, 8'h04, 8'h00, 8'h01, 0, 8'h00));
        tv.push_back(mk(0, 16'h0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h01, 0, 8'h00));
        tv.push_back(mk(0, 16'h0, 8'h00, 0, 0, 8'h01, 8'h01, 8'h01, 0, 8'h00));
        tv.push_back(mk(0, IFA,   8'h13, 0, 1, 8'h01, 8'h02, 8'h11, 0, 8'h00));
        tv.push_back(mk(0, IFA,   8'h00, 1, 0, 8'h01, 8'h00, 8'h11, 1, 8'hF1));
        tv.push_back(mk(0, IFA,   8'h00, 1, 0, 8'h01, 8'h00, 8'h11, 1, 8'hF1));
        tv.push_back(mk(0, 16'h0, 8'h00, 0, 0, 8'h01, 8'h00, 8'h11, 0, 8'h00));
        tv.push_back(mk(0, IFA,   8'hFF, 0, 1, 8'h01, 8'h00, 8'h1F, 0, 8'h00));
        tv.push_back(mk(0, IFA,   8'h00, 1, 0, 8'h01, 8'h00, 8'h1F, 1, 8'hFF));
        tv.push_back(mk(0, IFA,   8'h08, 0, 1, 8'h01, 8'h00, 8'h08, 0, 8'h00));
        tv.push_back(mk(0, IFA,   8'h00, 1, 0, 8'h01, 8'h00, 8'h08, 1, 8'hE8));
        tv.push_back(mk(0, OTH,   8'h00, 1, 0, 8'h01, 8'h00, 8'h08, 0, 8'h00));
        tv.push_back(mk(0, OTH,   8'h00, 1, 0, 8'h01, 8'h00, 8'h08, 0, 8'h00));
        tv.push_back(mk(0, OTH,   8'h00, 0, 1, 8'h01, 8'h00, 8'h08, 0, 8'h00));
        tv.push_back(mk(0, IFA,   8'h02, 1, 1, 8'h01, 8'h00, 8'h02, 1, 8'hE2));
        tv.push_back(mk(1, IFA,   8'h00, 1, 0, 8'h01, 8'h00, 8'h00, 0, 8'h00));
        tv.push_back(mk(1, 16'h0, 8'h00, 0, 0, 8'h1F, 8'h00, 8'h00, 0, 8'h00));
        tv.push_back(mk(0, 16'h0, 8'h00, 0, 0, 8'h1F, 8'h00, 8'h00, 0, 8'h00));
        tv.push_back(mk(0, 16'h0, 8'h00, 0, 0, 8'h1F, 8'h00, 8'h00, 0, 8'h00));
        tv.push_back(mk(0, IFA,   8'h00, 1, 0, 8'h1F, 8'h00, 8'h00, 1, 8'hE0));
        tv.push_back(mk(0, 16'h0, 8'h00, 0, 0, 8'h0F, 8'h00, 8'h00, 0, 8'h00));
        tv.push_back(mk(0, IFA,   8'h00, 0, 1, 8'h1F, 8'h10, 8'h10, 0, 8'h00));
        tv.push_back(mk(1, IFA,   8'hFF, 0, 1, 8'h00, 8'h00, 8'h00, 0, 8'h00));

        for (int i = 0; i < tv.size(); i++) apply(tv[i], i);

        // Held level: one set only, ack clears it, re-set needs low-then-high.
        apply(mk(0, 16'h0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00), 100);
        apply(mk(0, 16'h0, 8'h00, 0, 0, 8'h04, 8'h00, 8'h04, 0, 8'h00), 101);
        for (int i = 0; i < 10; i++)
            apply(mk(0, 16'h0, 8'h00, 0, 0, 8'h04, 8'h00, 8'h04, 0, 8'h00), 110 + i);
        apply(mk(0, 16'h0, 8'h00, 0, 0, 8'h04, 8'h04, 8'h00, 0, 8'h00), 120);
        for (int i = 0; i < 3; i++)
            apply(mk(0, 16'h0, 8'h00, 0, 0, 8'h04, 8'h00, 8'h00, 0, 8'h00), 121 + i);
        apply(mk(0, 16'h0, 8'h00, 0, 0, 8'h00, 8'h04, 8'h00, 0, 8'h00), 124);
        // Ack still held when the fresh edge arrives: edge must win.
        apply(mk(0, 16'h0, 8'h00, 0, 0, 8'h04, 8'h04, 8'h04, 0, 8'h00), 125);
        apply(mk(0, 16'h0, 8'h00, 0, 0, 8'h04, 8'h04, 8'h00, 0, 8'h00), 126);

        // Long read, then reset in the middle of it.
        apply(mk(0, IFA, 8'h00, 1, 0, 8'h06, 8'h00, 8'h02, 1, 8'hE2), 130);
        apply(mk(0, IFA, 8'h00, 1, 0, 8'h06, 8'h00, 8'h02, 1, 8'hE2), 131);
        apply(mk(1, IFA, 8'h00, 1, 0, 8'h06, 8'h00, 8'h00, 0, 8'h00), 132);
        apply(mk(0, IFA, 8'h00, 1, 0, 8'h06, 8'h00, 8'h00, 1, 8'hE0), 133);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
